// File: rtl/line_raster_unit.sv
// line_raster_unit: 4-deep command FIFO feeding a Bresenham line stepper (IDLE/LOAD/DRAW).
// Build macro LINE_RASTER_CLIP_EN: pixels outside 640x480 are stepped silently instead of presented.
module line_raster_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        abort,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [10:0] cmd_x0,
    input  logic [10:0] cmd_y0,
    input  logic [10:0] cmd_x1,
    input  logic [10:0] cmd_y1,
    input  logic        cmd_color,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [10:0] pix_x,
    output logic [10:0] pix_y,
    output logic        pix_color,
    output logic        line_done,
    output logic        busy
);
    localparam int ERR_W = 12;
    localparam logic [10:0] CLIP_W = 11'd640;
    localparam logic [10:0] CLIP_H = 11'd480;

    typedef enum logic [1:0] {IDLE, LOAD, DRAW} state_t;

    state_t                  r_state, w_state_nxt;
    logic [44:0]             r_fifo [4];
    logic [1:0]              r_wptr, r_rptr;
    logic [2:0]              r_count;
    logic [44:0]             r_cmd;
    logic                    w_push, w_pop, w_fifo_ne;
    logic [10:0]             w_x0, w_y0, w_x1, w_y1;
    logic signed [ERR_W-1:0] w_ddx, w_ddy, w_abs_dx, w_abs_dy;
    logic signed [ERR_W-1:0] r_dx, r_dy, r_err, w_err_nxt, w_add_x, w_add_y;
    logic                    r_sx, r_sy;
    logic [10:0]             r_cx, r_cy, w_cx_nxt, w_cy_nxt;
    logic signed [ERR_W:0]   w_e2, w_dx_ext, w_dy_ext;
    logic                    w_step_x, w_step_y, w_at_end, w_clip;
    logic                    w_draw, w_accept, w_adv;

    assign w_fifo_ne = (r_count != 3'd0);
    assign cmd_ready = (r_count != 3'd4);
    assign w_push    = cmd_valid & cmd_ready & ~abort;
    assign busy      = w_fifo_ne | (r_state != IDLE);

    // Entry layout {color, y1, x1, y0, x0}
    assign {w_y1, w_x1, w_y0, w_x0} = r_cmd[43:0];

    assign w_ddx    = $signed({1'b0, w_x1}) - $signed({1'b0, w_x0});
    assign w_ddy    = $signed({1'b0, w_y1}) - $signed({1'b0, w_y0});
    assign w_abs_dx = w_ddx[ERR_W-1] ? -w_ddx : w_ddx;
    assign w_abs_dy = w_ddy[ERR_W-1] ? -w_ddy : w_ddy;

    // 2*err needs one extra bit, so the step comparisons run at 13 bits
    assign w_e2     = {r_err, 1'b0};
    assign w_dx_ext = {r_dx[ERR_W-1], r_dx};
    assign w_dy_ext = {r_dy[ERR_W-1], r_dy};
    assign w_step_x = (w_e2 >= w_dy_ext);
    assign w_step_y = (w_e2 <= w_dx_ext);
    assign w_add_x  = w_step_x ? r_dy : '0;
    assign w_add_y  = w_step_y ? r_dx : '0;
    assign w_err_nxt = r_err + w_add_x + w_add_y;
    assign w_cx_nxt = !w_step_x ? r_cx : (r_sx ? r_cx - 11'd1 : r_cx + 11'd1);
    assign w_cy_nxt = !w_step_y ? r_cy : (r_sy ? r_cy - 11'd1 : r_cy + 11'd1);
    assign w_at_end = (r_cx == w_x1) && (r_cy == w_y1);

`ifdef LINE_RASTER_CLIP_EN
    assign w_clip = (r_cx >= CLIP_W) || (r_cy >= CLIP_H);
`else
    assign w_clip = 1'b0;
`endif

    assign w_draw    = (r_state == DRAW);
    assign w_accept  = w_draw & (pix_ready | w_clip);
    assign pix_valid = w_draw & ~w_clip;
    assign pix_x     = r_cx;
    assign pix_y     = r_cy;
    assign pix_color = r_cmd[44];

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_adv       = 1'b0;
        line_done   = 1'b0;
        if (abort) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_fifo_ne) begin
                        w_pop       = 1'b1;
                        w_state_nxt = LOAD;
                    end
                end
                LOAD: w_state_nxt = DRAW;
                DRAW: begin
                    if (w_accept) begin
                        if (w_at_end) begin
                            line_done = 1'b1;
                            if (w_fifo_ne) begin
                                w_pop       = 1'b1;
                                w_state_nxt = LOAD;
                            end else begin
                                w_state_nxt = IDLE;
                            end
                        end else begin
                            w_adv = 1'b1;
                        end
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= 2'd0;
            r_rptr  <= 2'd0;
            r_count <= 3'd0;
        end else if (abort) begin
            r_wptr  <= 2'd0;
            r_rptr  <= 2'd0;
            r_count <= 3'd0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 2'd1;
            if (w_pop)  r_rptr <= r_rptr + 2'd1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wptr] <= {cmd_color, cmd_y1, cmd_x1, cmd_y0, cmd_x0};
    end

    // Current command and pixel position are visible on outputs, so they clear on reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cmd <= '0;
            r_cx  <= 11'd0;
            r_cy  <= 11'd0;
        end else begin
            if (w_pop) r_cmd <= r_fifo[r_rptr];
            if (r_state == LOAD) begin
                r_cx <= w_x0;
                r_cy <= w_y0;
            end else if (w_adv) begin
                r_cx <= w_cx_nxt;
                r_cy <= w_cy_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == LOAD) begin
            r_dx  <= w_abs_dx;
            r_dy  <= -w_abs_dy;
            r_err <= w_abs_dx - w_abs_dy;
            r_sx  <= w_ddx[ERR_W-1];
            r_sy  <= w_ddy[ERR_W-1];
        end else if (w_adv) begin
            r_err <= w_err_nxt;
        end
    end

endmodule

// File: tb/tb_line_raster_unit.sv
// Scoreboard bench for line_raster_unit: directed lines with hand-listed pixels, plus
// latency, backpressure, abort and asynchronous reset scenarios.
module tb_line_raster_unit;
    logic        clk = 1'b0;
    logic        reset, abort, cmd_valid, cmd_ready, cmd_color;
    logic [10:0] cmd_x0, cmd_y0, cmd_x1, cmd_y1;
    logic        pix_valid, pix_ready, pix_color, line_done, busy;
    logic [10:0] pix_x, pix_y;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        c;
        logic        last;
        logic [7:0]  gap;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    bit   sb_en = 1'b0;
    int   cyc = 0;
    int   last_acc = 0;
    int   done_cnt = 0;

    line_raster_unit dut (
        .clk(clk), .reset(reset), .abort(abort),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
        .cmd_color(cmd_color),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
        .line_done(line_done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic exp_px(input int x, input int y, input int c, input int last, input int gap);
        exp_t e;
        e.x = 11'(x); e.y = 11'(y); e.c = 1'(c); e.last = 1'(last); e.gap = 8'(gap);
        sb_q.push_back(e);
    endtask

    task automatic push_cmd(input int x0, input int y0, input int x1, input int y1, input int c);
        bit ok;
        ok = 1'b0;
        cmd_x0 = 11'(x0); cmd_y0 = 11'(y0); cmd_x1 = 11'(x1); cmd_y1 = 11'(y1);
        cmd_color = 1'(c);
        cmd_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1'b1; break; end
        end
        if (!ok) chk("cmd_ready_timeout", 32'(ok), 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !busy) begin ok = 1'b1; break; end
        end
        chk(name, 32'(ok), 1);
        @(posedge clk); #1;
    endtask

    // Monitor: every accepted pixel is popped from the scoreboard and compared
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (line_done) done_cnt++;
            if (sb_en) begin
                if (pix_valid && pix_ready) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_pixel", 32'(sb_q.size()), 1);
                    end else begin
                        e = sb_q.pop_front();
                        chk("pixel{x,y,c,done}", {pix_x, pix_y, pix_color, line_done},
                            {e.x, e.y, e.c, e.last});
                        if (e.gap != 0) chk("pixel_gap", 32'(cyc - last_acc), 32'(e.gap));
                    end
                    last_acc = cyc;
                end
`ifndef LINE_RASTER_CLIP_EN
                else if (line_done) begin
                    chk("stray_line_done", 32'(pix_valid && pix_ready), 1);
                end
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k, d0, npix;
        bit          ok;
        logic [21:0] px;

        reset = 1'b0; abort = 1'b0; cmd_valid = 1'b0; pix_ready = 1'b1; cmd_color = 1'b0;
        cmd_x0 = '0; cmd_y0 = '0; cmd_x1 = '0; cmd_y1 = '0;
        #12;
        chk("reset_ctrl{valid,done,busy,ready}", {pix_valid, line_done, busy, cmd_ready}, 4'b0001);
        chk("reset_pix{x,y,c}", {pix_x, pix_y, pix_color}, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        sb_en = 1'b1;

        // Horizontal line and first-pixel latency
        exp_px(10, 20, 1, 0, 0);
        for (int x = 11; x <= 13; x++) exp_px(x, 20, 1, 0, 1);
        exp_px(14, 20, 1, 1, 1);
        push_cmd(10, 20, 14, 20, 1);
        k = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (pix_valid) begin k = i; break; end
        end
        chk("first_pixel_latency", 32'(k), 3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("hline_consecutive", 32'(pix_valid), 1);
        end
        wait_idle("hline_complete");

        // Steep line, busy drops after line_done
        exp_px(0, 0, 0, 0, 0);
        exp_px(0, 1, 0, 0, 1);
        exp_px(1, 2, 0, 0, 1);
        exp_px(1, 3, 0, 0, 1);
        exp_px(2, 4, 0, 0, 1);
        exp_px(2, 5, 0, 1, 1);
        push_cmd(0, 0, 2, 5, 0);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (line_done) begin ok = 1'b1; break; end
        end
        chk("steep_line_done_seen", 32'(ok), 1);
        @(negedge clk);
        @(negedge clk);
        chk("steep_busy_after_done", 32'(busy), 0);
        wait_idle("steep_complete");

        // Five queued commands, FIFO full, mid-line stall
        pix_ready = 1'b0;
        exp_px(0, 0, 1, 0, 0);
        exp_px(1, 1, 1, 0, 1);
        exp_px(2, 1, 1, 0, 0);
        exp_px(3, 2, 1, 0, 1);
        exp_px(4, 2, 1, 1, 1);
        exp_px(5, 5, 0, 0, 2);
        exp_px(6, 6, 0, 0, 1);
        exp_px(7, 7, 0, 0, 1);
        exp_px(8, 8, 0, 1, 1);
        exp_px(20, 3, 1, 0, 2);
        exp_px(19, 3, 1, 0, 1);
        exp_px(18, 3, 1, 0, 1);
        exp_px(17, 3, 1, 1, 1);
        exp_px(7, 10, 0, 0, 2);
        exp_px(7, 9, 0, 0, 1);
        exp_px(7, 8, 0, 0, 1);
        exp_px(7, 7, 0, 1, 1);
        exp_px(100, 200, 1, 1, 2);
        push_cmd(0, 0, 4, 2, 1);
        push_cmd(5, 5, 8, 8, 0);
        push_cmd(20, 3, 17, 3, 1);
        push_cmd(7, 10, 7, 7, 0);
        push_cmd(100, 200, 100, 200, 1);
        @(negedge clk);
        chk("fifo_full_cmd_ready", 32'(cmd_ready), 0);
        chk("fifo_full_busy", 32'(busy), 1);
        @(posedge clk); #1;
        pix_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        pix_ready = 1'b0;
        px = {pix_x, pix_y};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("stall_freeze{valid,x,y}", {pix_valid, pix_x, pix_y}, {1'b1, px});
        end
        @(posedge clk); #1;
        pix_ready = 1'b1;
        wait_idle("queue_complete");

        // Right-edge line
`ifdef LINE_RASTER_CLIP_EN
        exp_px(638, 0, 1, 0, 0);
        exp_px(639, 0, 1, 0, 1);
`else
        exp_px(638, 0, 1, 0, 0);
        for (int x = 639; x <= 641; x++) exp_px(x, 0, 1, 0, 1);
        exp_px(642, 0, 1, 1, 1);
`endif
        d0 = done_cnt;
        push_cmd(638, 0, 642, 0, 1);
        wait_idle("edge_line_complete");
        chk("edge_line_done_count", 32'(done_cnt - d0), 1);

        // Abort mid-line with two commands queued
        sb_en = 1'b0;
        push_cmd(0, 0, 100, 0, 1);
        push_cmd(1, 1, 2, 2, 0);
        push_cmd(3, 3, 4, 4, 1);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (pix_valid && pix_x == 11'd50) begin ok = 1'b1; break; end
        end
        chk("abort_reach_x50", 32'(ok), 1);
        @(posedge clk); #1;
        abort = 1'b1;
        cmd_x0 = 11'd9; cmd_y0 = 11'd9; cmd_x1 = 11'd9; cmd_y1 = 11'd9; cmd_valid = 1'b1;
        @(negedge clk);
        chk("abort_cycle_no_done", 32'(line_done), 0);
        @(posedge clk); #1;
        abort = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("abort_flush{valid,busy,done,ready}", {pix_valid, busy, line_done, cmd_ready}, 4'b0001);
        d0 = done_cnt;
        npix = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pix_valid || busy) npix++;
        end
        chk("abort_no_activity", 32'(npix), 0);
        chk("abort_no_line_done", 32'(done_cnt - d0), 0);
        @(posedge clk); #1;

        // Asynchronous reset mid-line
        push_cmd(0, 5, 30, 5, 1);
        push_cmd(1, 1, 3, 3, 1);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (pix_valid && pix_x == 11'd10) begin ok = 1'b1; break; end
        end
        chk("reset_reach_x10", 32'(ok), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset_ctrl{valid,done,busy,ready}", {pix_valid, line_done, busy, cmd_ready}, 4'b0001);
        chk("async_reset_pix{x,y,c}", {pix_x, pix_y, pix_color}, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        npix = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (pix_valid || busy) npix++;
        end
        chk("post_reset_idle", 32'(npix), 0);
        @(posedge clk); #1;

        sb_en = 1'b1;
        exp_px(3, 4, 0, 0, 0);
        exp_px(4, 4, 0, 0, 1);
        exp_px(5, 4, 0, 1, 1);
        push_cmd(3, 4, 5, 4, 0);
        wait_idle("post_reset_line_complete");

        chk("scoreboard_empty", 32'(sb_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/line_raster_unit.md
LINE_RASTER_UNIT -- requirements
Module: line_raster_unit

Interface
REQ-001 The block SHALL have exactly one clock; reset SHALL be asynchronous and active-low.
REQ-002 Ports SHALL be:
- clk  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-low reset
- abort  in  1  synchronous flush of the FIFO and the line in progress
- cmd_valid  in  1  line command offered
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_x0, cmd_y0, cmd_x1, cmd_y1  in  11 each  endpoints, unsigned
- cmd_color  in  1  pixel colour
- pix_valid  out  1  pixel write strobe to framebuffer
- pix_ready  in  1  framebuffer accepts the pixel
- pix_x, pix_y  out  11 each  pixel coordinate
- pix_color  out  1  pixel colour
- line_done  out  1  one-cycle pulse when the last pixel of a line is accepted
- busy  out  1  FIFO non-empty or FSM not IDLE

Function
REQ-003 The block SHALL hold a 4-entry command FIFO (45 bits per entry); cmd_ready = not full.
REQ-004 A push SHALL occur only on cmd_valid & cmd_ready; commands SHALL be rasterised in arrival order.
REQ-005 The FSM SHALL have states IDLE, LOAD and DRAW.
REQ-006 IDLE: if the FIFO is non-empty, the FSM SHALL pop the head entry and go to LOAD next cycle; otherwise it SHALL stay in IDLE.
REQ-007 LOAD: the FSM SHALL register dx=|x1-x0|, dy=-|y1-y0|, sx/sy=+1 or -1, err=dx+dy (12-bit signed) and cur=(x0,y0), then go to DRAW.
REQ-008 DRAW: pix_valid SHALL be 1, with pix_x/pix_y=cur and pix_color=the command colour.
REQ-009 On pix_valid & pix_ready, cur SHALL advance by integer Bresenham:
- e2=2*err
- if e2>=dy: err+=dy, x+=sx
- if e2<=dx: err+=dx, y+=sy
REQ-010 While pix_ready=0, all pixel outputs and the internal state SHALL hold unchanged.
REQ-011 Each line SHALL emit exactly max(|dx|,|dy|)+1 pixels; both endpoints are inclusive.
REQ-012 A degenerate line (x0=x1, y0=y1) SHALL emit exactly one pixel.
REQ-013 When the pixel equal to (x1,y1) is accepted, line_done SHALL pulse for one cycle.
- If the FIFO is non-empty, the FSM SHALL pop and go directly to LOAD.
- Otherwise it SHALL go to IDLE.
- Result: one bubble cycle between back-to-back lines.
REQ-014 Latency: a command pushed into an empty FIFO while IDLE at cycle N SHALL present its first pixel with pix_valid=1 at cycle N+3 (pop N+1, LOAD N+2, DRAW N+3).
REQ-015 Push and pop in the same cycle SHALL be legal; occupancy is unchanged.
REQ-016 Read/write pointers SHALL be 2 bits and wrap modulo 4; the count SHALL be 3 bits.
REQ-017 abort=1 SHALL empty the FIFO and force IDLE on the next edge; pix_valid=0 from that edge; no line_done is emitted.
REQ-018 When abort coincides with cmd_valid, the command SHALL be discarded.
REQ-019 Arithmetic SHALL use 12-bit signed intermediates; 11-bit endpoints cannot overflow.

Reset
REQ-020 While reset=0, asynchronously:
- FSM=IDLE
- FIFO empty (pointers and count = 0)
- cmd_ready=1
- pix_valid=0, pix_x=0, pix_y=0, pix_color=0
- line_done=0, busy=0
REQ-021 Reset asserted mid-line SHALL discard the line and all queued commands.
REQ-022 Deassertion SHALL take effect at the first clk rising edge after reset=1.

Configuration
REQ-023 With macro LINE_RASTER_CLIP_EN defined:
- A pixel with pix_x>=640 or pix_y>=480 SHALL be stepped internally with pix_valid=0 and no wait on pix_ready.
- line_done SHALL still pulse at (x1,y1), even if that pixel is clipped.
REQ-024 With LINE_RASTER_CLIP_EN undefined:
- Every pixel SHALL be presented with pix_valid=1 regardless of coordinate.

Verification
REQ-025 Horizontal line: push (10,20)->(14,20), colour 1, pix_ready=1 -> pixels x=10..14 at y=20 on consecutive cycles; first pixel 3 cycles after the push; line_done with (14,20).
REQ-026 Steep line: push (0,0)->(2,5) -> 6 pixels (0,0),(0,1),(1,2),(1,3),(2,4),(2,5); busy=0 two cycles after line_done.
REQ-027 Backpressure and queueing:
- Push 5 commands back-to-back -> cmd_ready=0 on the cycle the FIFO holds 4.
- Hold pix_ready=0 for 7 cycles mid-line -> pix_x/pix_y frozen for those cycles.
- All 5 lines drawn in order, with a 1-cycle gap between lines.
REQ-028 Abort: abort=1 mid-way through (0,0)->(100,0) with 2 commands queued -> pix_valid=0 next cycle, busy=0, no line_done, and no further pixels.
REQ-029 Reset mid-line: drive reset=0 asynchronously between clk edges -> outputs reach reset values immediately, with no edge required.
REQ-030 Clipping: with LINE_RASTER_CLIP_EN defined, push (638,0)->(642,0) -> pix_valid=1 only for x=638 and x=639; line_done pulses 3 cycles later. Without the macro, 5 valid pixels.
